bcd_7seg_scan: RTL and testbench
================================

Name: bcd_7seg_scan

Overview:
- Parametrised multi-digit BCD to 7-segment display driver with time-multiplexed anode scanning.
- Builds on the single-digit combinational BCD decoder. Adds:
  - a captured display register,
  - a refresh prescaler and digit scan counter,
  - leading-zero blanking, decimal points and an invalid-code flag.
- Sits between the datapath, which supplies packed BCD digits, and the board's common-anode/cathode display pins.

Parameters:
- DIGITS, 4: number of BCD digits and anode lines; range 1..8.
- DIV, 1000: clock cycles each digit is driven per scan slot; minimum 2.
- SEG_ACTIVE_LOW, 0: 1 inverts seg and dp at the output register; anodes are unaffected.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- load  in  1  single-cycle strobe; captures bcd_in and dp_in.
- bcd_in  in  4*DIGITS  packed BCD; digit k occupies bits [4k+3:4k]; digit 0 is least significant.
- dp_in  in  DIGITS  per-digit decimal point, captured with load.
- blank_lz  in  1  leading-zero blanking enable; sampled live, not captured.
- seg  out  7  segments {a,b,c,d,e,f,g}, seg[6]=a.
- dp  out  1  decimal point of the selected digit.
- an  out  DIGITS  one-hot digit enable, active-high; an[k] selects digit k.
- err  out  1  set when the last captured value contains a code greater than 9.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - shadow registers, prescaler, digit index and err all go to 0;
  - seg=0, dp=0 and an=0, at the logical level before SEG_ACTIVE_LOW inversion.
  - Reset takes priority over load and scan. Asserting it mid-scan restarts the scan from digit 0.
- Capture:
  - On a clock edge with load=1, shadow_bcd<=bcd_in and shadow_dp<=dp_in.
  - err<=1 if any captured nibble is in 10..15, otherwise err<=0. err holds until the next load.
- Prescaler:
  - Counts 0..DIV-1 and wraps to 0.
  - At terminal count DIV-1, the digit index increments and wraps from DIGITS-1 to 0.
  - With DIGITS=1 the index stays at 0.
- Outputs: registered, one cycle of latency from index and shadow. The first edge after reset release drives an=1 (digit 0).
- Decode, 0..9, standard patterns:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - Codes 10..15 display a dash, 0000001.
- Leading-zero blanking, when blank_lz=1:
  - Digit k is blanked if k>0 and every shadow digit j>=k is 0. Blanked means seg=0 and dp=0.
  - The anode is still driven. Digit 0 is never blanked.
  - Invalid codes count as nonzero.
- Simultaneous events:
  - load and a terminal count on the same edge: both take effect.
  - The new index displays the new shadow value on the next edge.
  - A load never disturbs the prescaler or the index.
- an is always exactly one-hot outside reset.

Optional Feature:
- Macro: BCD_SCAN_BRIGHTNESS_EN.
- When defined:
  - Adds input port duty, 4 bits, placed after blank_lz.
  - an is driven only while prescaler < ((duty+1)*DIV)/16; for the rest of the slot, an=0 and seg and dp keep their values.
  - duty=15 gives the full slot. duty is sampled live.
- When undefined: no duty port; an is driven for the full slot.

Test Plan (DIGITS=4, DIV=4, SEG_ACTIVE_LOW=0):
- Reset, then load bcd_in=16'h1234, dp_in=4'b0100 -> an cycles 0001, 0010, 0100, 1000, each for 4 cycles.
  - seg: 0110011 (4), 1111001 (3), 1101101 (2) with dp=1, 0110000 (1); err=0.
- Load 16'h0007, blank_lz=1 -> digits 3..1 give seg=0, digit 0 gives seg=1110000.
  - Same load with blank_lz=0 -> digits 3..1 give 1111110.
- Load 16'h0000, blank_lz=1 -> only digit 0 shows 1111110.
- Load 16'h9A05 -> err=1 from the next cycle; digit 2 shows 0000001.
  - Then load 16'h1111 -> err=0.
- Assert rst_n=0 for one cycle mid-slot while an=0100 -> next cycle an=0, seg=0, err=0.
  - Scan restarts at an=0001 after release.
- BCD_SCAN_BRIGHTNESS_EN with DIV=16 and duty=3 -> each anode high for 4 of 16 cycles.
  - duty=15 -> high for 16 of 16 cycles.

Source files
------------

// File: rtl/bcd_7seg_scan_if.sv
// Display driver bus: captured BCD/decimal-point input side plus scanned segment/anode outputs.
// Latency: n/a (signal bundle only).
// Backpressure: none; load is a single-cycle strobe that is always accepted.
// Optional BCD_SCAN_BRIGHTNESS_EN adds the 4-bit duty input.
interface bcd_7seg_scan_if #(
  parameter int DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   bcd_in;
  logic [DIGITS-1:0]     dp_in;
  logic                  blank_lz;
`ifdef BCD_SCAN_BRIGHTNESS_EN
  logic [3:0]            duty;
`endif
  logic [6:0]            seg;
  logic                  dp;
  logic [DIGITS-1:0]     an;
  logic                  err;

`ifdef BCD_SCAN_BRIGHTNESS_EN
  modport master (output load, bcd_in, dp_in, blank_lz, duty,
                  input  seg, dp, an, err);
  modport slave  (input  load, bcd_in, dp_in, blank_lz, duty,
                  output seg, dp, an, err);
`else
  modport master (output load, bcd_in, dp_in, blank_lz,
                  input  seg, dp, an, err);
  modport slave  (input  load, bcd_in, dp_in, blank_lz,
                  output seg, dp, an, err);
`endif
endinterface

// File: rtl/bcd_7seg_scan.sv
// Multi-digit BCD to 7-segment scanner: shadow capture, prescaled anode scan, leading-zero blanking, err flag.
// Latency: seg/dp/an registered one cycle after index and shadow; err valid the cycle after load.
// Backpressure: none; load always accepted and never disturbs the scan. Macro BCD_SCAN_BRIGHTNESS_EN adds duty dimming.
module bcd_7seg_scan #(
  parameter int DIGITS         = 4,
  parameter int DIV            = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input logic           clk,
  input logic           rst_n,
  bcd_7seg_scan_if.slave bus
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [4*DIGITS-1:0] shadow_bcd;
  logic [DIGITS-1:0]   shadow_dp;
  logic                err_q;
  logic [PW-1:0]       presc;
  logic [IW-1:0]       idx;
  logic [6:0]          seg_q;
  logic                dp_q;
  logic [DIGITS-1:0]   an_q;

  logic                any_bad;
  logic [3:0]          cur_code;
  logic                cur_dp;
  logic                cur_blank;
  logic                an_gate;
  logic                slot_end;

  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000001;
    endcase
    return s;
  endfunction

  // Flag any non-BCD nibble in the value being offered for capture.
  always_comb begin
    any_bad = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (bus.bcd_in[4*k +: 4] > 4'd9) any_bad = 1'b1;
    end
  end

  // Select the current digit; it is blanked when it and every higher digit is zero
  // (invalid codes are nonzero, so they are never blanked away).
  always_comb begin
    cur_code  = shadow_bcd[4*idx +: 4];
    cur_dp    = shadow_dp[idx];
    cur_blank = bus.blank_lz && (idx != '0) &&
                ((shadow_bcd >> {idx, 2'b00}) == '0);
    slot_end  = (presc == PW'(DIV - 1));
  end

`ifdef BCD_SCAN_BRIGHTNESS_EN
  logic [31:0] on_limit;
  // Anode on-window shrinks to (duty+1)/16 of the slot; duty is taken live.
  always_comb begin
    on_limit = ((32'(bus.duty) + 32'd1) * 32'(DIV)) / 32'd16;
    an_gate  = (32'(presc) < on_limit);
  end
`else
  // Without dimming the anode is on for the whole slot.
  always_comb begin
    an_gate = 1'b1;
  end
`endif

  // Capture the display value and its validity on load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_bcd <= '0;
      shadow_dp  <= '0;
      err_q      <= 1'b0;
    end else if (bus.load) begin
      shadow_bcd <= bus.bcd_in;
      shadow_dp  <= bus.dp_in;
      err_q      <= any_bad;
    end
  end

  // Refresh prescaler and digit index; independent of load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
    end else if (slot_end) begin
      presc <= '0;
      idx   <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Register segment, decimal point and one-hot anode for the current index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_q <= '0;
      dp_q  <= 1'b0;
      an_q  <= '0;
    end else begin
      seg_q <= cur_blank ? 7'b0 : decode(cur_code);
      dp_q  <= cur_dp & ~cur_blank;
      an_q  <= an_gate ? (DIGITS'(1) << idx) : '0;
    end
  end

  assign bus.seg = SEG_ACTIVE_LOW ? ~seg_q : seg_q;
  assign bus.dp  = SEG_ACTIVE_LOW ? ~dp_q  : dp_q;
  assign bus.an  = an_q;
  assign bus.err = err_q;

endmodule

// File: tb/tb_bcd_7seg_scan.sv
// Bench for bcd_7seg_scan: directed display scenarios then random loads, scoreboarded against a slot-time model.
// Latency: expected values queued per edge; monitor compares 1 time unit after each rising edge.
// Backpressure: none. Define BCD_SCAN_BRIGHTNESS_EN to exercise duty dimming (DIV becomes 16).
module tb_bcd_7seg_scan;

  localparam int ND = 4;
`ifdef BCD_SCAN_BRIGHTNESS_EN
  localparam int DIVP = 16;
`else
  localparam int DIVP = 4;
`endif

  typedef struct packed {
    logic [6:0]    seg;
    logic          dp;
    logic [ND-1:0] an;
    logic          err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  bcd_7seg_scan_if #(.DIGITS(ND)) bus ();

  bcd_7seg_scan #(.DIGITS(ND), .DIV(DIVP), .SEG_ACTIVE_LOW(1'b0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  exp_t expq[$];

  logic [6:0] tbl [0:9] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                            7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

  // Reference state: what has been loaded and how many scan cycles have elapsed since reset.
  logic [15:0] m_bcd = '0;
  logic [3:0]  m_dp  = '0;
  logic        m_err = 1'b0;
  int          m_cyc = 0;

  function automatic logic has_bad(input logic [15:0] v);
    for (int k = 0; k < ND; k++) if (((v >> (4*k)) & 16'hF) > 9) return 1'b1;
    return 1'b0;
  endfunction

  // Drive one edge's worth of inputs and queue the output expected after that edge.
  task automatic step(input bit rst, input bit ld, input logic [15:0] bcd,
                      input logic [3:0] dpv, input bit blz, input logic [3:0] dty);
    exp_t e;
    int   d, nib;
    bit   blanked;
    @(negedge clk);
    rst_n        = ~rst;
    bus.load     = ld;
    bus.bcd_in   = bcd;
    bus.dp_in    = dpv;
    bus.blank_lz = blz;
`ifdef BCD_SCAN_BRIGHTNESS_EN
    bus.duty     = dty;
`endif
    if (rst) begin
      e     = '0;
      m_bcd = '0;
      m_dp  = '0;
      m_err = 1'b0;
      m_cyc = 0;
    end else begin
      d       = (m_cyc / DIVP) % ND;
      nib     = int'((m_bcd >> (4*d)) & 16'hF);
      blanked = blz && (d > 0) && ((m_bcd >> (4*d)) == 0);
      e.seg   = blanked ? 7'b0 : ((nib < 10) ? tbl[nib] : 7'b0000001);
      e.dp    = blanked ? 1'b0 : m_dp[d];
      e.an    = ND'(1) << d;
`ifdef BCD_SCAN_BRIGHTNESS_EN
      if ((m_cyc % DIVP) >= ((int'(dty) + 1) * DIVP) / 16) e.an = '0;
`endif
      if (ld) begin
        m_bcd = bcd;
        m_dp  = dpv;
        m_err = has_bad(bcd);
      end
      e.err = m_err;
      m_cyc++;
    end
    expq.push_back(e);
  endtask

  task automatic idle(input int n, input bit blz, input logic [3:0] dty);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 4'h0, blz, dty);
  endtask

  // Monitor: pop one expectation per edge and compare each output field.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      checks++;
      if (bus.seg !== e.seg) begin
        errors++;
        $display("FAIL seg t=%0t got %b exp %b", $time, bus.seg, e.seg);
      end
      checks++;
      if (bus.dp !== e.dp) begin
        errors++;
        $display("FAIL dp t=%0t got %b exp %b", $time, bus.dp, e.dp);
      end
      checks++;
      if (bus.an !== e.an) begin
        errors++;
        $display("FAIL an t=%0t got %b exp %b", $time, bus.an, e.an);
      end
      checks++;
      if (bus.err !== e.err) begin
        errors++;
        $display("FAIL err t=%0t got %b exp %b", $time, bus.err, e.err);
      end
    end
  end

  initial begin
    logic [15:0] rb;
    rst_n        = 1'b0;
    bus.load     = 1'b0;
    bus.bcd_in   = '0;
    bus.dp_in    = '0;
    bus.blank_lz = 1'b0;
`ifdef BCD_SCAN_BRIGHTNESS_EN
    bus.duty     = 4'hF;
`endif
    // Reset state
    step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0, 4'hF);
    step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0, 4'hF);

    // 1234 with dp on digit 2, full scan twice
    step(1'b0, 1'b1, 16'h1234, 4'b0100, 1'b0, 4'hF);
    idle(2*ND*DIVP, 1'b0, 4'hF);

    // Leading-zero blanking on and off
    step(1'b0, 1'b1, 16'h0007, 4'b0000, 1'b1, 4'hF);
    idle(ND*DIVP + 2, 1'b1, 4'hF);
    step(1'b0, 1'b1, 16'h0007, 4'b0000, 1'b0, 4'hF);
    idle(ND*DIVP + 2, 1'b0, 4'hF);
    step(1'b0, 1'b1, 16'h0000, 4'b1111, 1'b1, 4'hF);
    idle(ND*DIVP + 2, 1'b1, 4'hF);

    // Invalid code, then clear it
    step(1'b0, 1'b1, 16'h9A05, 4'b0000, 1'b1, 4'hF);
    idle(ND*DIVP + 2, 1'b1, 4'hF);
    step(1'b0, 1'b1, 16'h1111, 4'b0000, 1'b0, 4'hF);

    // Reset mid-slot while digit 2 is showing
    for (int i = 0; i < 4*ND*DIVP; i++) begin
      if (((m_cyc - 1) / DIVP) % ND == 2 && ((m_cyc - 1) % DIVP) == 1) break;
      step(1'b0, 1'b0, 16'h0, 4'h0, 1'b0, 4'hF);
    end
    step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0, 4'hF);
    idle(ND*DIVP + 2, 1'b0, 4'hF);

`ifdef BCD_SCAN_BRIGHTNESS_EN
    // Dimmed then full duty
    step(1'b0, 1'b1, 16'h5678, 4'b0001, 1'b0, 4'd3);
    idle(2*ND*DIVP, 1'b0, 4'd3);
    idle(ND*DIVP, 1'b0, 4'd15);
`endif

    // Random loads, blanking and duty
    for (int i = 0; i < 400; i++) begin
      rb = 16'($urandom);
      if ($urandom_range(0, 2) != 0) rb = rb & 16'h7777;
      if ($urandom_range(0, 3) == 0) rb = rb & 16'h00FF;
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 4) == 0), rb,
           4'($urandom), 1'($urandom), 4'($urandom));
    end
    idle(3, 1'b0, 4'hF);

    @(negedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
